// File: rtl/non_restoring_divider_if.sv
// Request/response bundle between the ALU sequencer and the multi-cycle divider.
// The sequencer is the master: it drives the operands and start, the divider answers.
interface non_restoring_divider_if #(
  parameter int unsigned BITS = 32
);

  logic            start;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  div_by_zero,
    input  quotient,
    input  remainder
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output div_by_zero,
    output quotient,
    output remainder
  );

endinterface

// File: rtl/non_restoring_divider.sv
// Multi-cycle signed divider: non-restoring division on operand magnitudes, one quotient bit
// per cycle, with the signs of quotient and remainder applied in a final fix-up cycle.
module non_restoring_divider #(
  parameter int unsigned BITS = 32
) (
  input logic                    clk,
  input logic                    reset,
  non_restoring_divider_if.slave bus
);

  localparam int unsigned CntW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BITS - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StIter  = 3'd2;
  localparam logic [2:0] StFixup = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [BITS-1:0] dividend_q, dividend_d;
  logic [BITS-1:0] divisor_q, divisor_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] d_q, d_d;
  logic [BITS:0]   p_q, p_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            zero_q, zero_d;
  logic            dbz_q, dbz_d;
  logic [BITS-1:0] quotient_q, quotient_d;
  logic [BITS-1:0] remainder_q, remainder_d;

  // Shared BITS+1-wide adder: subtract is add of ~D with carry-in 1.
  logic [BITS:0]   p_shift;
  logic [BITS:0]   d_ext;
  logic [BITS:0]   add_b;
  logic            add_sub;
  logic [BITS:0]   add_sum;
  logic [BITS:0]   p_fix;
  logic [BITS-1:0] rem_mag;
  logic [BITS-1:0] q_fix;
  logic [BITS-1:0] r_fix;

  always_comb begin
    p_shift = {p_q[BITS-1:0], a_q[BITS-1]};
    d_ext   = {1'b0, d_q};
    add_sub = ~p_q[BITS];
    add_b   = add_sub ? ~d_ext : d_ext;
    add_sum = p_shift + add_b + {{BITS{1'b0}}, add_sub};

    // A negative final partial remainder is one divisor short.
    p_fix   = p_q[BITS] ? (p_q + d_ext) : p_q;
    rem_mag = p_fix[BITS-1:0];
    q_fix   = q_neg_q ? -a_q : a_q;
    r_fix   = (r_neg_q && (rem_mag != '0)) ? -rem_mag : rem_mag;
  end

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    a_d         = a_q;
    d_d         = d_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          dividend_d = bus.dividend;
          divisor_d  = bus.divisor;
          dbz_d      = 1'b0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        // Magnitudes are unsigned, so the most negative operand maps to 2^(BITS-1).
        a_d     = dividend_q[BITS-1] ? -dividend_q : dividend_q;
        d_d     = divisor_q[BITS-1] ? -divisor_q : divisor_q;
        q_neg_d = dividend_q[BITS-1] ^ divisor_q[BITS-1];
        r_neg_d = dividend_q[BITS-1];
        p_d     = '0;
        cnt_d   = '0;
        zero_d  = (divisor_q == '0);
        state_d = (divisor_q == '0) ? StFixup : StIter;
      end
      StIter: begin
        p_d   = add_sum;
        a_d   = {a_q[BITS-2:0], ~add_sum[BITS]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StFixup;
        end
      end
      StFixup: begin
        // Divide-by-zero skips the iterations but still spends this cycle.
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = dividend_q;
          dbz_d       = 1'b1;
        end else begin
          p_d         = p_fix;
          quotient_d  = q_fix;
          remainder_d = r_fix;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dividend_q  <= '0;
      divisor_q   <= '0;
      a_q         <= '0;
      d_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      a_q         <= a_d;
      d_q         <= d_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.busy        = (state_q == StLoad) || (state_q == StIter) || (state_q == StFixup);
  assign bus.done        = (state_q == StDone);
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;

  done_single_pulse: assert property (@(posedge clk) disable iff (reset) bus.done |=> !bus.done);

endmodule

// File: tb/tb_non_restoring_divider.sv
// Scoreboard bench for the signed divider: expected results are queued at issue time and
// compared when done pulses, along with latency, busy and reset behaviour.
module tb_non_restoring_divider;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  non_restoring_divider_if #(.BITS(32)) bus ();

  non_restoring_divider #(.BITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 32'd0) begin
      e.q   = 32'hffff_ffff;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      e.q   = 32'h8000_0000;
      e.r   = 32'd0;
      e.dbz = 1'b0;
    end else begin
      e.q   = 32'($signed(a) / $signed(b));
      e.r   = 32'($signed(a) % $signed(b));
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Issue one operation; optionally pulse start with other operands mid-flight.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke);
    int   cyc;
    bit   seen;
    exp_t e;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (poke && cyc == 5) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd12345;
        bus.divisor  = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      if (cyc > 0 && !bus.busy) check("busy_held", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(cyc), (b == 32'd0) ? 32'd2 : 32'd34);
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      check("quotient", bus.quotient, e.q);
      check("remainder", bus.remainder, e.r);
      check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
      @(posedge clk);
      #1;
      check("done_one_cycle", {31'd0, bus.done}, 32'd0);
      check("idle_after_done", {31'd0, bus.busy}, 32'd0);
      check("quotient_hold", bus.quotient, e.q);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(32'd100, 32'd7, 1'b0);
    run_op(-32'sd100, 32'd7, 1'b0);
    run_op(32'd100, -32'sd7, 1'b0);
    run_op(32'd7, 32'd0, 1'b0);
    run_op(32'h8000_0000, 32'hffff_ffff, 1'b0);

    // Abort at iteration counter 10: LOAD after the start edge, counter k after k+1 more edges.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("busy_before_abort", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_quotient", bus.quotient, 32'd0);
    check("abort_remainder", bus.remainder, 32'd0);
    check("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd9, 32'd3, 1'b0);

    run_op(32'd1000, 32'd3, 1'b1);
    run_op(-32'sd7, 32'd0, 1'b1);
    run_op(32'h8000_0000, 32'd1, 1'b0);
    run_op(32'd5, 32'd9, 1'b0);

    for (int i = 0; i < 24; i++) begin
      a = (($urandom & 3) == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($signed($urandom_range(0, 40)) - 20);
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      run_op(a, b, i[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
